// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per request over a
// req/ack memory handshake and presents the decoded fields to the controller.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              pcmux_N  = 2,
  localparam int             SELW     = (pcmux_N > 1) ? $clog2(pcmux_N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instrre,
  input  logic            pcnextctl,
  input  logic [SELW-1:0] pcmuxctl,
  input  logic [XLEN-1:0] pctarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [1:0]      func7b50,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic            instr_valid,
  output logic            misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] pc_next;
  logic            target_bad;

  assign pcplus4  = pc + XLEN'(4);
  assign opcode   = instr[6:0];
  assign func3    = instr[14:12];
  assign func7b50 = {instr[30], instr[25]};

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    pc_next    = pc;
    target_bad = 1'b0;
    if (pcnextctl) begin
      if (pcmuxctl == SELW'(0)) begin
        pc_next = pcplus4;
      end else if (pcmuxctl == SELW'(1)) begin
        if (pctarget[1:0] != 2'b00) target_bad = 1'b1;
        else                        pc_next    = pctarget;
      end
    end
  end

  // PC updates are independent of the fetch FSM; the request address is
  // captured at launch, so redirects during REQ never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      pc           <= pc_next;
      misalign_err <= target_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (instrre) begin
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata[31:0];
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory responder with variable
// wait states, a PC reference model and a monitor checking every fetched word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrre;
  logic        pcnextctl;
  logic [0:0]  pcmuxctl;
  logic [31:0] pctarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [1:0]  func7b50;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        misalign_err;

  fetch_unit dut (
    .clk(clk), .rst(rst), .instrre(instrre), .pcnextctl(pcnextctl),
    .pcmuxctl(pcmuxctl), .pctarget(pctarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .func3(func3), .func7b50(func7b50),
    .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] model_pc    = 32'h0;
  logic [31:0] launch_addr = 32'h0;
  bit          model_busy  = 1'b0;
  int          since_launch = 0;
  logic [31:0] exp_q[$];

  // Responder configuration (written by stimulus only)
  int          ack_wait   = 0;
  bit          force_en   = 1'b0;
  logic [31:0] force_word = 32'h0;
  int          stale_req  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait cycles of imem_req, or injects a stale ack.
  initial begin
    int cnt = 0;
    int stale_done = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        cnt      = 0;
        imem_ack = 1'b0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        cnt      = 0;
      end else if (stale_req > stale_done) begin
        stale_done = stale_done + 1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req) begin
        if (cnt >= ack_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = force_en ? force_word : mem_word(imem_addr);
        end else begin
          cnt = cnt + 1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: each new instr_valid pops the scoreboard and checks word and fields.
  initial begin
    logic        last_v = 1'b0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_v = 1'b0;
      end else begin
        if (instr_valid && !last_v) begin
          check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("instr", instr, w);
            check("opcode", 32'(opcode), 32'(w[6:0]));
            check("func3", 32'(func3), 32'(w[14:12]));
            check("func7b50", 32'(func7b50), 32'({w[30], w[25]}));
          end
        end
        last_v = instr_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // One clock cycle of stimulus; model predicts pc, misalign and the launch address.
  task automatic step(input bit re, input bit nx, input logic sel, input logic [31:0] tgt);
    bit mis    = 1'b0;
    bit launch = re && !model_busy;
    instrre   = re;
    pcnextctl = nx;
    pcmuxctl  = sel;
    pctarget  = tgt;
    if (launch) begin
      exp_q.push_back(force_en ? force_word : mem_word(model_pc));
      launch_addr  = model_pc;
      model_busy   = 1'b1;
      since_launch = 0;
    end
    if (nx) begin
      if (sel == 1'b0)          model_pc = model_pc + 32'd4;
      else if (tgt[1:0] != 2'b00) mis    = 1'b1;
      else                       model_pc = tgt;
    end
    @(posedge clk); #1;
    instrre   = 1'b0;
    pcnextctl = 1'b0;
    since_launch++;
    check("pc", pc, model_pc);
    check("pcplus4", pcplus4, model_pc + 32'd4);
    check("misalign_err", 32'(misalign_err), 32'(mis));
    check("imem_addr", imem_addr, launch_addr);
    if (launch) check("imem_req_launch", 32'(imem_req), 32'd1);
  endtask

  task automatic rand_step();
    logic [31:0] r = $urandom;
    logic [31:0] t = $urandom;
    t[1:0] = r[2] ? 2'b10 : 2'b00;
    step(1'b0, r[0], r[1], t);
  endtask

  task automatic finish_fetch(input int wait_n, input bit rnd);
    int guard = 0;
    while (!instr_valid && guard < 40) begin
      if (rnd) rand_step();
      else     step(1'b0, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("valid_seen", 32'(instr_valid), 32'd1);
    check("latency", 32'(since_launch), 32'(wait_n + 2));
    model_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instrre = 1'b0; pcnextctl = 1'b0; pcmuxctl = 1'b0; pctarget = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Zero-wait fetch of addi
    ack_wait = 0; force_en = 1'b1; force_word = 32'h00A0_0093;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    finish_fetch(0, 1'b0);
    check("addi_opcode", 32'(opcode), 32'h13);
    check("addi_func3", 32'(func3), 32'h0);

    // Three wait states with a pc+4 commit during REQ
    ack_wait = 3; force_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    finish_fetch(3, 1'b0);
    check("pc_after_inc", pc, 32'h4);

    // Misaligned target rejected, aligned target accepted
    step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check("pc_target", pc, 32'h100);

    // Wrap of pc+4
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("pc_wrap", pc, 32'h0);

    // Reset in the middle of a long request, then a stale ack
    ack_wait = 1000;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_async_req", 32'(imem_req), 32'd0);
    exp_q.delete();
    model_pc = 32'h0; launch_addr = 32'h0; model_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_wait = 0;
    stale_req++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stale_imem_req", 32'(imem_req), 32'd0);
    check("stale_instr", instr, 32'h0000_0013);
    check("stale_valid", 32'(instr_valid), 32'd0);

    // R-type sub, then mul launched from HOLD with a same-cycle pc commit
    force_en = 1'b1; force_word = 32'h4020_8033; ack_wait = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    finish_fetch(1, 1'b0);
    check("sub_func7b50", 32'(func7b50), 32'h2);
    force_word = 32'h0220_8033; ack_wait = 0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    finish_fetch(0, 1'b0);
    check("mul_func7b50", 32'(func7b50), 32'h1);

    // Randomized fetches with random wait states and PC traffic
    force_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] r = $urandom;
      logic [31:0] t = $urandom;
      t[1:0] = r[2] ? 2'b01 : 2'b00;
      ack_wait = int'($urandom_range(0, 3));
      step(1'b1, r[0], r[1], t);
      finish_fetch(ack_wait, 1'b1);
      repeat (int'($urandom_range(0, 2))) rand_step();
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
